gcd_param: RTL

Parametrised, W-bit binary (Stein) GCD engine with a start/done handshake, zero-operand detection and an iteration counter. It succeeds the fixed 8-bit subtractive GCD controller/datapath pair. The block sits behind a host or control FSM: the host presents two operands, pulses `go`, and reads `out` and `cycles` once `done` asserts.

---
 rtl/gcd_pkg.sv | 23 ++
 rtl/gcd_stein_dp.sv | 113 +++++++++++
 rtl/gcd_param.sv | 139 +++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the Stein GCD engine.
//   gcd_state_t : controller state encoding (3-bit codes, 6/7 unused)
//   ST_W        : width of the state encoding
//   gcd_cw()    : default width of the iteration counter for a given W
package gcd_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_REDUCE  = 3'd3,
    ST_DONE    = 3'd4,
    ST_INVALID = 3'd5
  } gcd_state_t;

  // Counter wide enough for the worst-case SHIFT+REDUCE count (< 4W).
  function automatic int gcd_cw(input int w);
    return $clog2(4 * w) + 1;
  endfunction

endpackage

// File: rtl/gcd_stein_dp.sv
// gcd_stein_dp: datapath of the binary GCD engine.
// Holds working operands a/b, the common power-of-two count k, the result
// register and the saturating cycle counter. All actions are strobed by the
// controller; status flags are purely combinational from a/b.
//   clk, rst        : clock, asynchronous active-low reset
//   ld              : load operands, clear k and cycles
//   shift_both      : a>>=1, b>>=1, k++
//   shift_a/shift_b : halve a single operand
//   sub_ab/sub_ba   : a-=b / b-=a (caller guarantees minuend is larger)
//   ld_out          : capture result into out
//   cnt_en          : count one SHIFT/REDUCE cycle (saturating)
//   a_eq_b ... b_zero : status flags to the controller
//   out, cycles     : result and iteration count
module gcd_stein_dp #(
  parameter int W  = 8,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [W-1:0]  data_in1,
  input  logic [W-1:0]  data_in2,
  input  logic          shift_both,
  input  logic          shift_a,
  input  logic          shift_b,
  input  logic          sub_ab,
  input  logic          sub_ba,
  input  logic          ld_out,
  input  logic          cnt_en,
  output logic          a_eq_b,
  output logic          a_gt_b,
  output logic          a_even,
  output logic          b_even,
  output logic          a_zero,
  output logic          b_zero,
  output logic [W-1:0]  out,
  output logic [CW-1:0] cycles
);

  localparam int KW = $clog2(W) + 1;

  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [KW-1:0] k_reg;
  logic [W-1:0]  out_reg;
  logic [W-1:0]  out_next;
  logic [CW-1:0] cycles_reg;

  assign a_eq_b = (a_reg == b_reg);
  assign a_gt_b = (a_reg > b_reg);
  assign a_even = ~a_reg[0];
  assign b_even = ~b_reg[0];
  assign a_zero = (a_reg == '0);
  assign b_zero = (b_reg == '0);

  // With one operand zero the other is the answer (k is still 0 then);
  // both zero yields 0. Otherwise a==b and the common factor is restored.
  always_comb begin
    out_next = a_reg << k_reg;
    if (a_zero) begin
      out_next = b_reg;
    end else if (b_zero) begin
      out_next = a_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0;
      b_reg <= '0;
      k_reg <= '0;
    end else if (ld) begin
      a_reg <= data_in1;
      b_reg <= data_in2;
      k_reg <= '0;
    end else if (shift_both) begin
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
      k_reg <= k_reg + KW'(1);
    end else if (shift_a) begin
      a_reg <= a_reg >> 1;
    end else if (shift_b) begin
      b_reg <= b_reg >> 1;
    end else if (sub_ab) begin
      a_reg <= a_reg - b_reg;
    end else if (sub_ba) begin
      b_reg <= b_reg - a_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_reg <= '0;
    end else if (ld_out) begin
      out_reg <= out_next;
    end
  end

  // Saturating counter: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_reg <= '0;
    end else if (ld) begin
      cycles_reg <= '0;
    end else if (cnt_en && (cycles_reg != '1)) begin
      cycles_reg <= cycles_reg + CW'(1);
    end
  end

  assign out    = out_reg;
  assign cycles = cycles_reg;

endmodule

// File: rtl/gcd_param.sv
// gcd_param: W-bit binary (Stein) GCD engine with go/done handshake.
// Controller FSM lives here; arithmetic lives in gcd_stein_dp.
//   clk, rst            : clock, asynchronous active-low reset
//   go                  : start request, honoured only in IDLE
//   data_in1, data_in2  : operands, captured on the accepting edge
//   out                 : GCD result, held until next accepted go
//   cycles              : SHIFT+REDUCE cycles of the last operation
//   idle, busy          : status decoded from the present state
//   done                : one-cycle pulse in DONE or INVALID
//   invalid             : one-cycle pulse when both operands were zero
//   ps                  : present-state code
module gcd_param
  import gcd_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = gcd_cw(W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [W-1:0]    data_in1,
  input  logic [W-1:0]    data_in2,
  output logic [W-1:0]    out,
  output logic [CW-1:0]   cycles,
  output logic            idle,
  output logic            busy,
  output logic            done,
  output logic            invalid,
  output logic [ST_W-1:0] ps
);

  gcd_state_t state_reg;
  gcd_state_t state_next;

  logic ld, shift_both, shift_a, shift_b, sub_ab, sub_ba, ld_out, cnt_en;
  logic a_eq_b, a_gt_b, a_even, b_even, a_zero, b_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ld         = 1'b0;
    shift_both = 1'b0;
    shift_a    = 1'b0;
    shift_b    = 1'b0;
    sub_ab     = 1'b0;
    sub_ba     = 1'b0;
    ld_out     = 1'b0;
    cnt_en     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (go) begin
          ld         = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (a_zero && b_zero) begin
          ld_out     = 1'b1;
          state_next = ST_INVALID;
        end else if (a_zero || b_zero) begin
          ld_out     = 1'b1;
          state_next = ST_DONE;
        end else begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cnt_en = 1'b1;
        if (a_even && b_even) begin
          shift_both = 1'b1;
        end else begin
          state_next = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        cnt_en = 1'b1;
        if (a_even) begin
          shift_a = 1'b1;
        end else if (b_even) begin
          shift_b = 1'b1;
        end else if (a_eq_b) begin
          ld_out     = 1'b1;
          state_next = ST_DONE;
        end else if (a_gt_b) begin
          sub_ab = 1'b1;
        end else begin
          sub_ba = 1'b1;
        end
      end
      ST_DONE, ST_INVALID: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  gcd_stein_dp #(
    .W  (W),
    .CW (CW)
  ) u_dp (
    .clk        (clk),
    .rst        (rst),
    .ld         (ld),
    .data_in1   (data_in1),
    .data_in2   (data_in2),
    .shift_both (shift_both),
    .shift_a    (shift_a),
    .shift_b    (shift_b),
    .sub_ab     (sub_ab),
    .sub_ba     (sub_ba),
    .ld_out     (ld_out),
    .cnt_en     (cnt_en),
    .a_eq_b     (a_eq_b),
    .a_gt_b     (a_gt_b),
    .a_even     (a_even),
    .b_even     (b_even),
    .a_zero     (a_zero),
    .b_zero     (b_zero),
    .out        (out),
    .cycles     (cycles)
  );

  assign idle    = (state_reg == ST_IDLE);
  assign busy    = (state_reg == ST_CHECK) || (state_reg == ST_SHIFT) ||
                   (state_reg == ST_REDUCE);
  assign done    = (state_reg == ST_DONE) || (state_reg == ST_INVALID);
  assign invalid = (state_reg == ST_INVALID);
  assign ps      = state_reg;

endmodule
